univ_shift_reg: RTL and testbench
=================================

// Module: univ_shift_reg
// PURPOSE
//   Parametrised universal shift register; successor to the fixed serial-in/serial-out register.
//   Modes: hold, shift right, shift left and parallel load, plus an optional rotate mode.
//   A word counter pulses word_done after every WIDTH consecutive shifts.
//   Used as SISO/SIPO/PISO front-end for serial links and bit-serial datapaths.
// PARAMETERS
//   WIDTH   4  register length in bits (>=2); also the shifts per word
//   ROTATE  0  1: shift modes rotate (sin_r/sin_l ignored); 0: serial inputs fill the vacated bit
//   CNT_W   $clog2(WIDTH)  width of shift_cnt (localparam, derived)
// PORTS
//   clk        in   1      sole clock; all state updates on posedge clk
//   rst        in   1      synchronous reset, active-high
//   en         in   1      1: execute mode this cycle; 0: hold (same as MODE_HOLD)
//   mode       in   2      00 hold, 01 shift right, 10 shift left, 11 parallel load
//   sin_r      in   1      serial input entering q[WIDTH-1] on shift right
//   sin_l      in   1      serial input entering q[0] on shift left
//   pin        in   WIDTH  parallel load data
//   pout       out  WIDTH  register contents q (registered)
//   sout_r     out  1      q[0]: bit that leaves on the next right shift
//   sout_l     out  1      q[WIDTH-1]: bit that leaves on the next left shift
//   shift_cnt  out  CNT_W  shifts taken since last load/reset/word boundary
//   word_done  out  1      one-cycle pulse, registered
// BEHAVIOUR
//   Reset (rst=1 at posedge): q=0, shift_cnt=0, word_done=0; rst overrides en/mode. Mid-word reset discards the partial word.
//   All outputs come straight from flops (sout_r/sout_l are bit selects of q); no combinational input->output path.
//   Per posedge with rst=0, en=1:
//     hold : q, shift_cnt unchanged; word_done<=0
//     right: q <= {ROTATE ? q[0] : sin_r, q[WIDTH-1:1]}
//     left : q <= {q[WIDTH-2:0], ROTATE ? q[WIDTH-1] : sin_l}
//     load : q <= pin; shift_cnt<=0; word_done<=0
//   en=0: identical to hold (word_done<=0).
//   Counter (right and left shifts both count; direction change does not clear it):
//     shift_cnt==WIDTH-1 and shift -> shift_cnt<=0, word_done<=1 for exactly the next cycle.
//     Otherwise shift -> shift_cnt<=shift_cnt+1, word_done<=0.
//   Continuous shifting: word_done is high one cycle in every WIDTH; never high two cycles in a row (WIDTH>=2).
//   Latency (SISO use, right shift): sin_r captured at edge k is visible on sout_r after edge k+WIDTH-1.
//   Load and shift are mutually exclusive by encoding; a load in the cycle that would have completed a word
//   takes precedence. The load produces no word_done pulse and restarts the count.
//   Unknown mode values cannot occur (2-bit, fully decoded).
// STRUCTURE
//   Shared package usr_pkg: localparams MODE_HOLD=2'b00, MODE_SHR=2'b01, MODE_SHL=2'b10, MODE_LOAD=2'b11.
//   Optional sub-module shift_word_counter (WIDTH param; inc/clr in; cnt, done out); data path stays inline.
//   No other sub-modules; one always block for q, one for counter/word_done.
// TESTING (WIDTH=4 unless stated)
//   1. rst=1 for 2 cycles with pin=4'hF, mode=LOAD -> pout=0, shift_cnt=0, word_done=0.
//   2. SISO: en=1, mode=SHR, sin_r = 1,0,1,1 on edges 1..4 -> sout_r = 1,0,1,1 after edges 4..7.
//      pout=4'b1101 after edge 4; word_done high after edges 4 and 8 only.
//   3. LOAD pin=4'b1001, then SHL with sin_l=0 x2 -> pout 0010, 0100; sout_l=0 then 0.
//   4. ROTATE=1: LOAD 4'b0001, SHR x4 with sin_r=1 -> pout 1000,0100,0010,0001; word_done after 4th shift.
//   5. Shift 3 times, then LOAD 4'hA on 4th cycle -> pout=4'hA, shift_cnt=0, no word_done.
//      Next 4 shifts -> word_done once.
//   6. Shift 2, en=0 for 3 cycles, shift 2 -> pout unchanged while en=0, word_done after the 4th shift.
//      Repeat with rst after 2 shifts -> count restarts, q=0.

Source files
------------

// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register.
// Mode encodings for the 2-bit mode input.
package usr_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

endpackage

// File: rtl/shift_word_counter.sv
// Counts shifts modulo WIDTH and pulses done after each full word.
// Ports: clk, rst (sync, active-high), inc, clr -> cnt, done (registered).
module shift_word_counter #(
  parameter  int WIDTH = 4,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             done
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt  <= '0;
      done <= 1'b0;
    end else if (inc) begin
      if (cnt == LAST) begin
        cnt  <= '0;
        done <= 1'b1;
      end else begin
        cnt  <= cnt + 1'b1;
        done <= 1'b0;
      end
    end else begin
      done <= 1'b0;
    end
  end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift right/left (or rotate), load.
// Ports: clk, rst, en, mode, sin_r, sin_l, pin -> pout, sout_r, sout_l,
//        shift_cnt, word_done; all outputs come straight from flops.
module univ_shift_reg
  import usr_pkg::*;
#(
  parameter  int WIDTH  = 4,
  parameter  bit ROTATE = 1'b0,
  localparam int CNT_W  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic [WIDTH-1:0] pin,
  output logic [WIDTH-1:0] pout,
  output logic             sout_r,
  output logic             sout_l,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             word_done
);

  logic [WIDTH-1:0] q;
  logic shr, shl, ld;
  logic rin, lin;

  assign shr = en && (mode == MODE_SHR);
  assign shl = en && (mode == MODE_SHL);
  assign ld  = en && (mode == MODE_LOAD);

  // Bit entering the vacated end: wrap-around in rotate builds.
  assign rin = ROTATE ? q[0]       : sin_r;
  assign lin = ROTATE ? q[WIDTH-1] : sin_l;

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else begin
      unique case (1'b1)
        shr:     q <= {rin, q[WIDTH-1:1]};
        shl:     q <= {q[WIDTH-2:0], lin};
        ld:      q <= pin;
        default: q <= q;
      endcase
    end
  end

  shift_word_counter #(
    .WIDTH(WIDTH)
  ) u_cnt (
    .clk (clk),
    .rst (rst),
    .inc (shr || shl),
    .clr (ld),
    .cnt (shift_cnt),
    .done(word_done)
  );

  assign pout   = q;
  assign sout_r = q[0];
  assign sout_l = q[WIDTH-1];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Randomised and directed bench for univ_shift_reg (plain and rotate).
// Both builds share inputs and are checked against an arithmetic model.
module tb_univ_shift_reg;
  import usr_pkg::*;

  localparam int W = 4;
  localparam int MASK = (1 << W) - 1;

  logic clk = 1'b0;
  logic rst, en, sin_r, sin_l;
  logic [1:0] mode;
  logic [W-1:0] pin;

  logic [W-1:0] p0, p1;
  logic sr0, sl0, sr1, sl1;
  logic [1:0] c0, c1;
  logic d0, d1;

  int n_chk = 0;
  int n_fail = 0;

  int mq0, mq1, nsh, mdone;

  always #5 clk = ~clk;

  univ_shift_reg #(.WIDTH(W), .ROTATE(1'b0)) u_dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode),
    .sin_r(sin_r), .sin_l(sin_l), .pin(pin),
    .pout(p0), .sout_r(sr0), .sout_l(sl0),
    .shift_cnt(c0), .word_done(d0)
  );

  univ_shift_reg #(.WIDTH(W), .ROTATE(1'b1)) u_rot (
    .clk(clk), .rst(rst), .en(en), .mode(mode),
    .sin_r(sin_r), .sin_l(sin_l), .pin(pin),
    .pout(p1), .sout_r(sr1), .sout_l(sl1),
    .shift_cnt(c1), .word_done(d1)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic int shr_v(int q, int b);
    return (q >> 1) | (b << (W - 1));
  endfunction

  function automatic int shl_v(int q, int b);
    return ((q << 1) & MASK) | b;
  endfunction

  task automatic model_step();
    bit sh;
    sh = 1'b0;
    if (rst) begin
      mq0 = 0; mq1 = 0; nsh = 0;
    end else if (en && mode == MODE_LOAD) begin
      mq0 = int'(pin); mq1 = int'(pin); nsh = 0;
    end else if (en && mode == MODE_SHR) begin
      mq0 = shr_v(mq0, int'(sin_r));
      mq1 = shr_v(mq1, mq1 & 1);
      nsh++; sh = 1'b1;
    end else if (en && mode == MODE_SHL) begin
      mq0 = shl_v(mq0, int'(sin_l));
      mq1 = shl_v(mq1, (mq1 >> (W - 1)) & 1);
      nsh++; sh = 1'b1;
    end
    mdone = (sh && (nsh % W == 0)) ? 1 : 0;
  endtask

  task automatic check_all();
    chk("pout", 32'(p0), 32'(mq0));
    chk("sout_r", 32'(sr0), 32'(mq0 & 1));
    chk("sout_l", 32'(sl0), 32'((mq0 >> (W-1)) & 1));
    chk("cnt", 32'(c0), 32'(nsh % W));
    chk("done", 32'(d0), 32'(mdone));
    chk("rot_pout", 32'(p1), 32'(mq1));
    chk("rot_sout_r", 32'(sr1), 32'(mq1 & 1));
    chk("rot_cnt", 32'(c1), 32'(nsh % W));
    chk("rot_done", 32'(d1), 32'(mdone));
  endtask

  task automatic step(input logic r, input logic e,
                      input logic [1:0] m,
                      input logic a, input logic b,
                      input logic [W-1:0] p);
    rst = r; en = e; mode = m;
    sin_r = a; sin_l = b; pin = p;
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  initial begin
    mq0 = 0; mq1 = 0; nsh = 0; mdone = 0;

    step(1, 1, MODE_LOAD, 0, 0, 4'hF);
    step(1, 1, MODE_LOAD, 0, 0, 4'hF);
    chk("rst_pout", 32'(p0), 32'h0);
    chk("rst_cnt", 32'(c0), 32'h0);
    chk("rst_done", 32'(d0), 32'h0);

    step(0, 1, MODE_SHR, 1, 0, 4'h0);
    step(0, 1, MODE_SHR, 0, 0, 4'h0);
    step(0, 1, MODE_SHR, 1, 0, 4'h0);
    step(0, 1, MODE_SHR, 1, 0, 4'h0);
    chk("siso_pout", 32'(p0), 32'hD);
    chk("siso_done4", 32'(d0), 32'h1);
    for (int i = 0; i < 4; i++)
      step(0, 1, MODE_SHR, 0, 0, 4'h0);
    chk("siso_done8", 32'(d0), 32'h1);

    step(0, 1, MODE_LOAD, 0, 0, 4'b1001);
    step(0, 1, MODE_SHL, 0, 0, 4'h0);
    chk("shl1", 32'(p0), 32'b0010);
    step(0, 1, MODE_SHL, 0, 0, 4'h0);
    chk("shl2", 32'(p0), 32'b0100);

    step(0, 1, MODE_LOAD, 0, 0, 4'b0001);
    for (int i = 0; i < 4; i++)
      step(0, 1, MODE_SHR, 1, 0, 4'h0);
    chk("rot_final", 32'(p1), 32'b0001);
    chk("rot_wd", 32'(d1), 32'h1);

    for (int i = 0; i < 3; i++)
      step(0, 1, MODE_SHL, 1, 1, 4'h0);
    step(0, 1, MODE_LOAD, 0, 0, 4'hA);
    chk("ld_pout", 32'(p0), 32'hA);
    chk("ld_cnt", 32'(c0), 32'h0);
    chk("ld_done", 32'(d0), 32'h0);
    for (int i = 0; i < 4; i++)
      step(0, 1, MODE_SHR, 0, 1, 4'h0);

    step(0, 1, MODE_SHR, 1, 0, 4'h0);
    step(0, 1, MODE_SHL, 0, 1, 4'h0);
    for (int i = 0; i < 3; i++)
      step(0, 0, MODE_SHR, 1, 1, 4'h5);
    step(0, 1, MODE_SHR, 1, 0, 4'h0);
    step(0, 1, MODE_SHR, 1, 0, 4'h0);
    chk("en0_done", 32'(d0), 32'h1);

    step(0, 1, MODE_SHR, 1, 0, 4'h0);
    step(0, 1, MODE_SHR, 1, 0, 4'h0);
    step(1, 1, MODE_SHR, 1, 0, 4'h0);
    chk("midrst_pout", 32'(p0), 32'h0);
    chk("midrst_cnt", 32'(c0), 32'h0);

    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 39) == 0),
           ($urandom_range(0, 7) != 0),
           2'($urandom_range(0, 3)),
           1'($urandom), 1'($urandom),
           4'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
